// File: rtl/bp_pkg.sv
// Package: bp_pkg
// Shared definitions for the branch resolve unit: the 2-bit counter
// encodings, the in-flight queue entry layout, and the saturating
// counter transition function used to train the branch history table.
package bp_pkg;

  localparam logic [1:0] ST_T  = 2'b11;  // strongly taken
  localparam logic [1:0] ST_WT = 2'b10;  // weakly taken
  localparam logic [1:0] ST_WN = 2'b01;  // weakly not-taken
  localparam logic [1:0] ST_N  = 2'b00;  // strongly not-taken

  // One in-flight branch: 32 + 2 + 32 = 66 bits.
  typedef struct packed {
    logic [31:0] pc;
    logic [1:0]  state;
    logic [31:0] target;
  } br_entry_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] sat2_next(input logic [1:0] state, input logic taken);
    logic [1:0] nxt;
    case (state)
      ST_N:    nxt = taken ? ST_WN : ST_N;
      ST_WN:   nxt = taken ? ST_WT : ST_N;
      ST_WT:   nxt = taken ? ST_T  : ST_WN;
      ST_T:    nxt = taken ? ST_T  : ST_WT;
      default: nxt = ST_N;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Interface: branch_resolve_unit_if
// Bundles the fetch push side, the EX resolve side and all status/result
// outputs of the branch resolve unit.
//   master : drives pred_* / ex_*, observes results (fetch/EX side, bench)
//   slave  : the branch resolve unit itself
interface branch_resolve_unit_if #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              pred_valid;
  logic [31:0]       pred_pc;
  logic [1:0]        pred_state;
  logic [31:0]       pred_target;
  logic              ex_valid;
  logic              ex_taken;
  logic [31:0]       ex_target;
  logic              q_full;
  logic [CW-1:0]     q_count;
  logic              upd_valid;
  logic [31:0]       upd_pc;
  logic [1:0]        upd_state;
  logic              flush;
  logic [31:0]       redirect_pc;
  logic [CNT_W-1:0]  br_count;
  logic [CNT_W-1:0]  miss_count;
  logic              err_ovf;
  logic              err_unf;

  modport master (
    output pred_valid, pred_pc, pred_state, pred_target,
    output ex_valid, ex_taken, ex_target,
    input  q_full, q_count, upd_valid, upd_pc, upd_state, flush, redirect_pc,
    input  br_count, miss_count, err_ovf, err_unf
  );

  modport slave (
    input  pred_valid, pred_pc, pred_state, pred_target,
    input  ex_valid, ex_taken, ex_target,
    output q_full, q_count, upd_valid, upd_pc, upd_state, flush, redirect_pc,
    output br_count, miss_count, err_ovf, err_unf
  );
endinterface

// File: rtl/br_inflight_fifo.sv
// Module: br_inflight_fifo
// DEPTH x 66-bit circular buffer of predicted branches awaiting resolution.
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push, din  write din at the tail (accepted if not full, or if popping)
//   pop, dout  dout is the head entry; pop advances the head (ignored if empty)
//   clear      drop all entries; takes priority over push and pop
//   count      entries held, full = (count == DEPTH), both registered
module br_inflight_fifo import bp_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   clear,
  input  br_entry_t              din,
  output br_entry_t              dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  br_entry_t       mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [PW:0]     count_r;
  logic [PW:0]     count_nxt_s;
  logic            full_r;
  logic            push_ok_s;
  logic            pop_ok_s;

  // Accept/advance decisions and the next occupancy.
  always_comb begin
    pop_ok_s    = pop && (count_r != '0);
    push_ok_s   = push && (!full_r || pop_ok_s);
    count_nxt_s = count_r;
    case ({push_ok_s, pop_ok_s})
      2'b10:   count_nxt_s = count_r + (PW+1)'(1);
      2'b01:   count_nxt_s = count_r - (PW+1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and full flag; pointers wrap naturally (DEPTH is 2^PW).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else if (clear) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      full_r   <= 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      count_r <= count_nxt_s;
      full_r  <= (count_nxt_s == DEPTH_C);
    end
  end

  // Entry storage; a cleared cycle writes nothing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
    end else if (push_ok_s && !clear) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  assign dout  = mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = full_r;
endmodule

// File: rtl/branch_resolve_unit.sv
// Module: branch_resolve_unit
// EX-stage companion of the 2-bit BHT. Holds predicted branches in flight,
// compares the oldest against the EX resolution, and produces the BHT
// training update plus flush/redirect toward the PC mux.
// Ports:
//   clk, rst  clock, asynchronous active-high reset
//   bus       branch_resolve_unit_if.slave: pred_* push, ex_* resolve,
//             q_full/q_count, upd_* pulse, flush/redirect_pc, statistics,
//             sticky err_ovf/err_unf. All result outputs are registered.
module branch_resolve_unit import bp_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  branch_resolve_unit_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  br_entry_t         head_s;
  br_entry_t         push_entry_s;
  logic [CW-1:0]     count_s;
  logic              full_s;
  logic              resolve_s;
  logic              unf_s;
  logic              ovf_s;
  logic              push_s;
  logic              mispredict_s;
  logic [1:0]        next_state_s;
  logic [31:0]       redirect_s;

  logic              upd_valid_r;
  logic [31:0]       upd_pc_r;
  logic [1:0]        upd_state_r;
  logic              flush_r;
  logic [31:0]       redirect_r;
  logic [CNT_W-1:0]  br_count_r;
  logic [CNT_W-1:0]  miss_count_r;
  logic              err_ovf_r;
  logic              err_unf_r;

  // Resolve compare and push/error qualification for this cycle.
  always_comb begin
    push_entry_s.pc     = bus.pred_pc;
    push_entry_s.state  = bus.pred_state;
    push_entry_s.target = bus.pred_target;
    resolve_s    = bus.ex_valid && (count_s != '0);
    unf_s        = bus.ex_valid && (count_s == '0);
    // Wrong direction, or right "taken" guess with a wrong target.
    mispredict_s = resolve_s &&
                   ((head_s.state[1] != bus.ex_taken) ||
                    (bus.ex_taken && head_s.state[1] && (head_s.target != bus.ex_target)));
    // A mispredict flushes the queue, so a same-cycle push is wrong-path and dropped silently.
    push_s       = bus.pred_valid && !mispredict_s;
    ovf_s        = bus.pred_valid && full_s && !resolve_s;
    next_state_s = sat2_next(head_s.state, bus.ex_taken);
    redirect_s   = bus.ex_taken ? bus.ex_target : (head_s.pc + 32'd4);
  end

  br_inflight_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_s),
    .pop   (resolve_s),
    .clear (mispredict_s),
    .din   (push_entry_s),
    .dout  (head_s),
    .count (count_s),
    .full  (full_s)
  );

  // Registered resolve results, statistics and sticky errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      upd_valid_r  <= 1'b0;
      upd_pc_r     <= 32'd0;
      upd_state_r  <= 2'b00;
      flush_r      <= 1'b0;
      redirect_r   <= 32'd0;
      br_count_r   <= '0;
      miss_count_r <= '0;
      err_ovf_r    <= 1'b0;
      err_unf_r    <= 1'b0;
    end else begin
      upd_valid_r <= resolve_s;
      flush_r     <= mispredict_s;
      if (resolve_s) begin
        upd_pc_r    <= head_s.pc;
        upd_state_r <= next_state_s;
      end
      if (mispredict_s) redirect_r <= redirect_s;
      if (resolve_s && (br_count_r != '1))      br_count_r   <= br_count_r + CNT_W'(1);
      if (mispredict_s && (miss_count_r != '1)) miss_count_r <= miss_count_r + CNT_W'(1);
      if (ovf_s) err_ovf_r <= 1'b1;
      if (unf_s) err_unf_r <= 1'b1;
    end
  end

  assign bus.q_full      = full_s;
  assign bus.q_count     = count_s;
  assign bus.upd_valid   = upd_valid_r;
  assign bus.upd_pc      = upd_pc_r;
  assign bus.upd_state   = upd_state_r;
  assign bus.flush       = flush_r;
  assign bus.redirect_pc = redirect_r;
  assign bus.br_count    = br_count_r;
  assign bus.miss_count  = miss_count_r;
  assign bus.err_ovf     = err_ovf_r;
  assign bus.err_unf     = err_unf_r;
endmodule

// File: tb/tb_branch_resolve_unit.sv
// Testbench: tb_branch_resolve_unit
// Directed scenarios with literal expectations, then randomized traffic,
// all checked every cycle against a queue-based behavioural model.
module tb_branch_resolve_unit;
  localparam int DEPTH = 4;
  localparam int CNT_W = 16;

  typedef struct {
    logic [31:0] pc;
    int          state;
    logic [31:0] target;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_resolve_unit_if #(.DEPTH(DEPTH), .CNT_W(CNT_W)) bus ();

  branch_resolve_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  ent_t        mq[$];
  logic        m_uv = 1'b0;
  logic [31:0] m_upc = 32'd0;
  int          m_ust = 0;
  logic        m_fl = 1'b0;
  logic [31:0] m_rpc = 32'd0;
  int          m_br = 0;
  int          m_miss = 0;
  logic        m_ovf = 1'b0;
  logic        m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int   n;
    bit   res, mis;
    ent_t e, p;
    if (rst) begin
      mq.delete();
      m_uv = 1'b0; m_upc = 32'd0; m_ust = 0; m_fl = 1'b0; m_rpc = 32'd0;
      m_br = 0; m_miss = 0; m_ovf = 1'b0; m_unf = 1'b0;
      return;
    end
    n    = mq.size();
    m_uv = 1'b0;
    m_fl = 1'b0;
    mis  = 1'b0;
    res  = bus.ex_valid && (n != 0);
    if (bus.ex_valid && n == 0) m_unf = 1'b1;
    if (res) begin
      e     = mq[0];
      m_uv  = 1'b1;
      m_upc = e.pc;
      if (bus.ex_taken) m_ust = (e.state == 3) ? 3 : e.state + 1;
      else              m_ust = (e.state == 0) ? 0 : e.state - 1;
      if (m_br < 65535) m_br++;
      if ((e.state >= 2) != bus.ex_taken) mis = 1'b1;
      else if (bus.ex_taken && e.target != bus.ex_target) mis = 1'b1;
      if (mis) begin
        m_fl  = 1'b1;
        m_rpc = bus.ex_taken ? bus.ex_target : e.pc + 32'd4;
        if (m_miss < 65535) m_miss++;
      end
    end
    if (mis) begin
      mq.delete();
    end else begin
      if (res) void'(mq.pop_front());
      if (bus.pred_valid) begin
        if (n < DEPTH || res) begin
          p.pc = bus.pred_pc; p.state = int'(bus.pred_state); p.target = bus.pred_target;
          mq.push_back(p);
        end else begin
          m_ovf = 1'b1;
        end
      end
    end
  endtask

  // Model advances on each clock edge and on asynchronous reset.
  initial forever begin
    @(posedge clk or posedge rst);
    model_step();
  end

  // Every-cycle compare of DUT outputs against the model.
  initial forever begin
    @(negedge clk);
    chk("q_count", 32'(bus.q_count), 32'(mq.size()));
    chk("q_full", 32'(bus.q_full), 32'(mq.size() == DEPTH));
    chk("upd_valid", 32'(bus.upd_valid), 32'(m_uv));
    chk("flush", 32'(bus.flush), 32'(m_fl));
    chk("br_count", 32'(bus.br_count), 32'(m_br));
    chk("miss_count", 32'(bus.miss_count), 32'(m_miss));
    chk("err_ovf", 32'(bus.err_ovf), 32'(m_ovf));
    chk("err_unf", 32'(bus.err_unf), 32'(m_unf));
    if (m_uv) begin
      chk("upd_pc", bus.upd_pc, m_upc);
      chk("upd_state", 32'(bus.upd_state), 32'(m_ust));
    end
    if (m_fl) chk("redirect_pc", bus.redirect_pc, m_rpc);
  end

  // Apply one cycle of inputs; returns at the following negedge.
  task automatic drv(input logic pv, input logic [31:0] pc, input logic [1:0] st,
                     input logic [31:0] tgt, input logic ev, input logic tk,
                     input logic [31:0] et);
    bus.pred_valid  = pv;
    bus.pred_pc     = pc;
    bus.pred_state  = st;
    bus.pred_target = tgt;
    bus.ex_valid    = ev;
    bus.ex_taken    = tk;
    bus.ex_target   = et;
    @(negedge clk);
  endtask

  task automatic idle();
    drv(1'b0, 32'd0, 2'b00, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  // Asynchronous reset pulse away from both clock edges.
  task automatic rst_pulse();
    bus.pred_valid = 1'b0;
    bus.ex_valid   = 1'b0;
    #2 rst = 1'b1;
    @(negedge clk);
    chk("rst_q_count", 32'(bus.q_count), 32'd0);
    chk("rst_flush", 32'(bus.flush), 32'd0);
    chk("rst_upd_valid", 32'(bus.upd_valid), 32'd0);
    chk("rst_br_count", 32'(bus.br_count), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    bus.pred_valid = 1'b0; bus.pred_pc = 32'd0; bus.pred_state = 2'b00; bus.pred_target = 32'd0;
    bus.ex_valid = 1'b0; bus.ex_taken = 1'b0; bus.ex_target = 32'd0;
    repeat (2) @(negedge clk);
    chk("init_q_count", 32'(bus.q_count), 32'd0);
    chk("init_q_full", 32'(bus.q_full), 32'd0);
    chk("init_upd_pc", bus.upd_pc, 32'd0);
    chk("init_redirect", bus.redirect_pc, 32'd0);
    rst = 1'b0;
    idle();

    // Training: weak not-taken resolved taken -> weak taken
    drv(1'b1, 32'h100, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h500);
    chk("train_upd_valid", 32'(bus.upd_valid), 32'd1);
    chk("train_upd_pc", bus.upd_pc, 32'h100);
    chk("train_upd_state", 32'(bus.upd_state), 32'd2);
    // Strong taken, correct target -> stays strong, no flush
    drv(1'b1, 32'h104, 2'b11, 32'h600, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h600);
    chk("sat_upd_state", 32'(bus.upd_state), 32'd3);
    chk("sat_flush", 32'(bus.flush), 32'd0);

    // Direction miss with two younger wrong-path entries
    drv(1'b1, 32'h200, 2'b10, 32'h300, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h210, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h220, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("dir_upd_state", 32'(bus.upd_state), 32'd1);
    chk("dir_flush", 32'(bus.flush), 32'd1);
    chk("dir_redirect", bus.redirect_pc, 32'h204);
    chk("dir_q_count", 32'(bus.q_count), 32'd0);

    // Target miss
    drv(1'b1, 32'h300, 2'b11, 32'h400, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b1, 32'h480);
    chk("tgt_flush", 32'(bus.flush), 32'd1);
    chk("tgt_redirect", bus.redirect_pc, 32'h480);
    chk("tgt_upd_state", 32'(bus.upd_state), 32'd3);

    // Full, overflow, then push+pop while full
    for (int i = 0; i < 4; i++) drv(1'b1, 32'h700 + 32'(i * 4), 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("full_q_full", 32'(bus.q_full), 32'd1);
    drv(1'b1, 32'h7F0, 2'b00, 32'h0, 1'b0, 1'b0, 32'h0);
    chk("ovf_err", 32'(bus.err_ovf), 32'd1);
    chk("ovf_q_count", 32'(bus.q_count), 32'd4);
    drv(1'b1, 32'h7F4, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("pp_q_count", 32'(bus.q_count), 32'd4);
    chk("pp_upd_pc", bus.upd_pc, 32'h700);
    chk("pp_flush", 32'(bus.flush), 32'd0);
    for (int i = 0; i < 4; i++) drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("drain_upd_pc", bus.upd_pc, 32'h7F4);
    chk("drain_q_count", 32'(bus.q_count), 32'd0);

    // Underflow, then PC+4 wrap on a not-taken mispredict
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("unf_err", 32'(bus.err_unf), 32'd1);
    chk("unf_upd_valid", 32'(bus.upd_valid), 32'd0);
    drv(1'b1, 32'hFFFF_FFFC, 2'b10, 32'h1000, 1'b0, 1'b0, 32'h0);
    drv(1'b0, 32'h0, 2'b00, 32'h0, 1'b1, 1'b0, 32'h0);
    chk("wrap_flush", 32'(bus.flush), 32'd1);
    chk("wrap_redirect", bus.redirect_pc, 32'h0000_0000);

    // Reset mid-stream
    drv(1'b1, 32'h800, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
    drv(1'b1, 32'h804, 2'b01, 32'h0, 1'b0, 1'b0, 32'h0);
    rst_pulse();
    chk("rst_err_ovf", 32'(bus.err_ovf), 32'd0);
    idle();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        rst_pulse();
      end else begin
        drv(($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            {$urandom_range(0, 32'hFFFF), 2'b00} + 32'h1000_0000,
            2'($urandom_range(0, 3)),
            ($urandom_range(0, 1) == 1) ? 32'h2000 : 32'h2004,
            ($urandom_range(0, 9) < 5) ? 1'b1 : 1'b0,
            2'($urandom_range(0, 1)) == 2'd1,
            ($urandom_range(0, 3) != 0) ? 32'h2000 : 32'h2004);
      end
    end
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
